// File: rtl/rom_bus_arbiter_if.sv
// rom_bus_arbiter_if
//   Groups the download port, the two read requesters, the single-port
//   memory port and the core status outputs of rom_bus_arbiter.
//   slave  : the arbiter side (drives acks, read data, memory port, status)
//   master : the host/testbench side (drives download, requests, MEM_DO)
// Parameter AW: memory address width.
interface rom_bus_arbiter_if #(
  parameter int AW = 15
);
  // HPS ioctl download
  logic          dl_active;
  logic          dl_wr;
  logic [24:0]   dl_ad;
  logic [7:0]    dl_dt;
  // read requester 0 (main CPU)
  logic          r0_req;
  logic [AW-1:0] r0_ad;
  logic          r0_ack;
  logic [7:0]    r0_dt;
  // read requester 1 (sub CPU)
  logic          r1_req;
  logic [AW-1:0] r1_ad;
  logic          r1_ack;
  logic [7:0]    r1_dt;
  // single-port ROM/BRAM
  logic [AW-1:0] mem_ad;
  logic [7:0]    mem_di;
  logic          mem_we;
  logic [7:0]    mem_do;
  // core control / status
  logic          core_rst;
  logic          loaded;
  logic [7:0]    cksum;

  modport slave (
    input  dl_active, dl_wr, dl_ad, dl_dt,
    input  r0_req, r0_ad, r1_req, r1_ad, mem_do,
    output r0_ack, r0_dt, r1_ack, r1_dt,
    output mem_ad, mem_di, mem_we,
    output core_rst, loaded, cksum
  );

  modport master (
    output dl_active, dl_wr, dl_ad, dl_dt,
    output r0_req, r0_ad, r1_req, r1_ad, mem_do,
    input  r0_ack, r0_dt, r1_ack, r1_dt,
    input  mem_ad, mem_di, mem_we,
    input  core_rst, loaded, cksum
  );
endinterface

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter
//   Owns the single-port game ROM. Writes the HPS ioctl download into it,
//   then shares it between two read requesters (R0 main CPU, R1 sub CPU)
//   with round-robin arbitration. Holds the game core in reset until a
//   download has completed and RST_HOLD cycles have elapsed.
// Ports:
//   mclk_i     : sole clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   bus        : rom_bus_arbiter_if.slave (download, R0/R1, memory, status)
// Parameters:
//   AW         : memory address width (download writes at/above 2**AW dropped)
//   RST_HOLD   : cycles CORE_RST stays high after DL_ACTIVE falls (>=1)
// Optional feature macro: ROMARB_CHECKSUM_EN
//   defined   -> CKSUM is an 8-bit wrap sum of accepted download bytes
//   undefined -> CKSUM tied to zero, no adder
module rom_bus_arbiter #(
  parameter int AW       = 15,
  parameter int RST_HOLD = 16
) (
  input  logic             mclk_i,
  input  logic             reset_n_i,
  rom_bus_arbiter_if.slave bus
);
  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, LOAD, HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_ad_q, mem_ad_d;
  logic [7:0]    mem_di_q, mem_di_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    r0_dt_q, r0_dt_d;
  logic [7:0]    r1_dt_q, r1_dt_d;
  logic          last_grant_q, last_grant_d; // 1 = R1 was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          core_rst_q, core_rst_d;
  logic          loaded_q, loaded_d;

  // Writes are accepted whenever DL_ACTIVE is high: the next state is LOAD
  // regardless, so the registered MEM_WE pulse always lands inside LOAD and a
  // write on the very first DL_ACTIVE cycle is not lost.
  logic in_range;
  logic wr_accept;
  assign in_range  = ((bus.dl_ad >> AW) == 25'd0);
  assign wr_accept = bus.dl_active && bus.dl_wr && in_range;

  always_comb begin
    state_d      = state_q;
    mem_ad_d     = mem_ad_q;
    mem_di_d     = mem_di_q;
    mem_we_d     = 1'b0;
    r0_dt_d      = r0_dt_q;
    r1_dt_d      = r1_dt_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    core_rst_d   = core_rst_q;
    loaded_d     = loaded_q;

    if (bus.dl_active) begin
      // Download pre-empts everything; an in-flight read is abandoned.
      state_d    = LOAD;
      core_rst_d = 1'b1;
      if (wr_accept) begin
        mem_we_d = 1'b1;
        mem_ad_d = bus.dl_ad[AW-1:0];
        mem_di_d = bus.dl_dt;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (loaded_q) begin
            // R0 wins unless R1 also requests and R0 was served last.
            if (bus.r0_req && (!bus.r1_req || last_grant_q)) begin
              mem_ad_d     = bus.r0_ad;
              last_grant_d = 1'b0;
              state_d      = ISSUE;
            end else if (bus.r1_req) begin
              mem_ad_d     = bus.r1_ad;
              last_grant_d = 1'b1;
              state_d      = ISSUE;
            end
          end
        end
        ISSUE: state_d = WAIT;          // memory samples MEM_AD on this edge
        WAIT: begin
          if (last_grant_q) r1_dt_d = bus.mem_do;
          else              r0_dt_d = bus.mem_do;
          state_d = ACK;
        end
        ACK:  state_d = IDLE;           // REQ deliberately ignored here
        LOAD: begin
          cnt_d   = CW'(RST_HOLD - 1);
          state_d = HOLD;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            loaded_d   = 1'b1;
            core_rst_d = 1'b0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      mem_ad_q     <= '0;
      mem_di_q     <= '0;
      mem_we_q     <= 1'b0;
      r0_dt_q      <= '0;
      r1_dt_q      <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      core_rst_q   <= 1'b1;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_ad_q     <= mem_ad_d;
      mem_di_q     <= mem_di_d;
      mem_we_q     <= mem_we_d;
      r0_dt_q      <= r0_dt_d;
      r1_dt_q      <= r1_dt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      core_rst_q   <= core_rst_d;
      loaded_q     <= loaded_d;
    end
  end

`ifdef ROMARB_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  // Cleared when LOAD is entered from any other state, then accumulates.
  always_comb begin
    cksum_d = cksum_q;
    if (bus.dl_active) begin
      if (state_q != LOAD) cksum_d = 8'h00;
      if (wr_accept)       cksum_d = cksum_d + bus.dl_dt;
    end
  end

  always_ff @(posedge mclk_i or negedge reset_n_i) begin
    if (!reset_n_i) cksum_q <= 8'h00;
    else            cksum_q <= cksum_d;
  end

  assign bus.cksum = cksum_q;
`else
  assign bus.cksum = 8'h00;
`endif

  assign bus.mem_ad   = mem_ad_q;
  assign bus.mem_di   = mem_di_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.r0_dt    = r0_dt_q;
  assign bus.r1_dt    = r1_dt_q;
  assign bus.r0_ack   = (state_q == ACK) && !last_grant_q;
  assign bus.r1_ack   = (state_q == ACK) &&  last_grant_q;
  assign bus.core_rst = core_rst_q;
  assign bus.loaded   = loaded_q;
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb_rom_bus_arbiter
//   Scoreboard bench for rom_bus_arbiter: expected memory writes and read
//   completions are queued when stimulus is driven and popped when the DUT
//   shows MEM_WE or an ACK. Includes a registered-read BRAM model.
module tb_rom_bus_arbiter;
  localparam int AW       = 15;
  localparam int RST_HOLD = 16;
`ifdef ROMARB_CHECKSUM_EN
  localparam logic [7:0] CKSUM_FULL = 8'h80;
`else
  localparam logic [7:0] CKSUM_FULL = 8'h00;
`endif

  logic clk;
  logic reset_n;

  rom_bus_arbiter_if #(.AW(AW)) bus ();

  rom_bus_arbiter #(.AW(AW), .RST_HOLD(RST_HOLD)) dut (
    .mclk_i    (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port BRAM, data valid the cycle after the address edge
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_ad] <= bus.mem_di;
    bus.mem_do <= mem[bus.mem_ad];
  end

  typedef struct packed { logic [AW-1:0] ad; logic [7:0] dt; } wr_t;
  typedef struct packed { logic port; logic [7:0] dt; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we) begin
      check("wr_q_empty", 32'(wr_q.size() == 0), 0);
      if (wr_q.size() != 0) begin
        wr_t e;
        e = wr_q.pop_front();
        check("mem_wr", {bus.mem_ad, bus.mem_di}, {e.ad, e.dt});
        $display("wr ad=%0h di=%0h", bus.mem_ad, bus.mem_di);
      end
    end
    if (bus.r0_ack || bus.r1_ack) begin
      check("rd_q_empty", 32'(rd_q.size() == 0), 0);
      check("ack_both", 32'(bus.r0_ack && bus.r1_ack), 0);
      if (rd_q.size() != 0) begin
        rd_t e;
        e = rd_q.pop_front();
        if (bus.r0_ack) check("rd0", {1'b0, bus.r0_dt}, {e.port, e.dt});
        else            check("rd1", {1'b1, bus.r1_dt}, {e.port, e.dt});
        $display("rd port=%0d dt=%0h", bus.r1_ack, bus.r1_ack ? bus.r1_dt : bus.r0_dt);
      end
    end
  end

  // Count edges after the one that first sees DL_ACTIVE low until CORE_RST drops.
  task automatic wait_core_rst_low(output int k);
    @(posedge clk);
    k = 0;
    while (k < 200) begin
      @(posedge clk); #1;
      k++;
      if (!bus.core_rst) break;
    end
  endtask

  // Registered requester: drops REQ in the cycle it sees its ACK.
  task automatic wait_pair(output int t0, output int t1);
    int n;
    bit d0, d1;
    n = 0; d0 = 0; d1 = 0; t0 = -1; t1 = -1;
    while (n < 40 && !(d0 && d1)) begin
      @(negedge clk);
      n++;
      if (bus.r0_ack && !d0) begin d0 = 1; t0 = n; bus.r0_req = 1'b0; end
      if (bus.r1_ack && !d1) begin d1 = 1; t1 = n; bus.r1_req = 1'b0; end
    end
    check("pair_done", {30'd0, d0, d1}, 3);
  endtask

  task automatic tie_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int t0, t1;
    @(posedge clk); #1;
    bus.r0_ad = a0; bus.r1_ad = a1;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    rd_q.push_back('{port: 1'b0, dt: a0[7:0]});
    rd_q.push_back('{port: 1'b1, dt: a1[7:0]});
    wait_pair(t0, t1);
    check("r0_ack_lat", t0, 4);
    check("r1_ack_lat", t1, 8);
    @(posedge clk); #1;
    check("r0_dt_hold", bus.r0_dt, {24'd0, a0[7:0]});
    check("r1_dt_hold", bus.r1_dt, {24'd0, a1[7:0]});
  endtask

  initial begin
    int acks;
    int k;
    reset_n = 1'b0;
    bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.dl_ad = '0; bus.dl_dt = '0;
    bus.r0_req = 1'b0; bus.r0_ad = '0; bus.r1_req = 1'b0; bus.r1_ad = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_rst", bus.core_rst, 1);
    check("rst_loaded", bus.loaded, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_ad", bus.mem_ad, 0);
    check("rst_acks", {bus.r0_ack, bus.r1_ack}, 0);
    check("rst_dt", {bus.r0_dt, bus.r1_dt}, 0);
    check("rst_cksum", bus.cksum, 0);
    reset_n = 1'b1;

    // requests before any download are never served
    bus.r0_req = 1'b1; bus.r0_ad = 15'h0005;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.r0_ack) acks++;
    end
    check("noload_acks", acks, 0);
    check("noload_core_rst", bus.core_rst, 1);
    check("noload_loaded", bus.loaded, 0);
    bus.r0_req = 1'b0;

    // download 0x00..0xFF, then one out-of-range write
    @(posedge clk); #1;
    bus.dl_active = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bus.dl_wr = 1'b1; bus.dl_ad = 25'(i); bus.dl_dt = 8'(i);
      wr_q.push_back('{ad: AW'(i), dt: 8'(i)});
    end
    @(posedge clk); #1;
    bus.dl_ad = 25'h8000; bus.dl_dt = 8'h5A;
    @(posedge clk); #1;
    bus.dl_wr = 1'b0; bus.dl_active = 1'b0;
    check("load_core_rst", bus.core_rst, 1);
    wait_core_rst_low(k);
    check("hold_cycles", k, RST_HOLD);
    check("load_loaded", bus.loaded, 1);
    check("load_cksum", bus.cksum, {24'd0, CKSUM_FULL});
    check("wr_q_left", wr_q.size(), 0);

    // simultaneous requests: R0 wins both ties
    tie_read(15'h0010, 15'h0020);
    tie_read(15'h0033, 15'h0044);

    // R1 read abandoned in ISSUE by a new download
    @(posedge clk); #1;
    bus.r1_req = 1'b1; bus.r1_ad = 15'h0030;
    @(posedge clk); #1;
    bus.dl_active = 1'b1;
    @(posedge clk); #1;
    check("drop_core_rst", bus.core_rst, 1);
    bus.r1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drop_r1_dt", bus.r1_dt, 8'h44);
    bus.dl_active = 1'b0;
    wait_core_rst_low(k);
    check("hold_cycles2", k, RST_HOLD);
    check("reload_cksum", bus.cksum, 0);

    // asynchronous reset in the middle of a read
    @(posedge clk); #1;
    bus.r0_req = 1'b1; bus.r0_ad = 15'h0040;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_core_rst", bus.core_rst, 1);
    check("arst_loaded", bus.loaded, 0);
    check("arst_mem_ad", bus.mem_ad, 0);
    check("arst_dt", {bus.r0_dt, bus.r1_dt}, 0);
    check("arst_acks", {bus.r0_ack, bus.r1_ack}, 0);
    check("arst_cksum", bus.cksum, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_loaded", bus.loaded, 0);
    check("post_rst_core_rst", bus.core_rst, 1);
    bus.r0_req = 1'b0;
    @(posedge clk); #1;
    check("rd_q_left", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
